output_link_tx: RTL and testbench

- Upstream end of the inter-router link for one router output port.
- Registers crossbar flits onto the link.
- Tracks each downstream input-buffer VC: allocation state, on/off flow-control status and release handshake.
- Exports free and on status to the local VC allocator and switch allocator; flags protocol violations.

---
 rtl/output_link_tx_pkg.sv | 34 +++
 rtl/output_link_tx_tracker.sv | 90 +++++++++
 rtl/output_link_tx.sv | 96 +++++++++
 tb/tb_output_link_tx.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/output_link_tx_pkg.sv
// Shared NoC link types: VC count, flit format and the upstream per-VC transmit state.
package noc_params;

    localparam int VC_NUM  = 4;
    localparam int VC_SIZE = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;

    typedef enum logic [1:0] {
        HEAD     = 2'd0,
        BODY     = 2'd1,
        TAIL     = 2'd2,
        HEADTAIL = 2'd3
    } flit_label_t;

    typedef struct packed {
        flit_label_t          label;
        logic [VC_SIZE-1:0]   vc_id;
        logic [15:0]          payload;
    } flit_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        ACTIVE = 2'd1,
        DRAIN  = 2'd2
    } vc_tx_state_t;

    function automatic logic is_head_label(input flit_label_t l);
        return (l == HEAD) || (l == HEADTAIL);
    endfunction

    function automatic logic is_tail_label(input flit_label_t l);
        return (l == TAIL) || (l == HEADTAIL);
    endfunction

endpackage

// File: rtl/output_link_tx_tracker.sv
// Tracks one downstream VC: FREE/ACTIVE/DRAIN state, head-sent bit, on/off status
// and this VC's protocol-violation term for the current cycle.
module downstream_vc_tracker
    import noc_params::*;
#(
    parameter int ON_OFF_SYNC = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        grant,
    input  logic        send,
    input  flit_label_t label,
    input  logic        rel,
    input  logic        on_off,
    output logic        free,
    output logic        on,
    output logic        err
);

    vc_tx_state_t state_reg, state_next;
    vc_tx_state_t s1, s2;
    logic         head_reg, head_next;
    logic         on_int;

    generate
        if (ON_OFF_SYNC != 0) begin : g_on_sync
            logic on_reg;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) on_reg <= 1'b1;
                else     on_reg <= on_off;
            end
            assign on_int = on_reg;
        end else begin : g_on_pass
            assign on_int = on_off;
        end
    endgenerate

    // Same-cycle events resolve in order: flit send, then release, then grant,
    // so HEADTAIL + release + regrant leaves the VC ACTIVE without error.
    always_comb begin
        state_next = state_reg;
        head_next  = head_reg;
        err        = 1'b0;
        s1         = state_reg;
        s2         = state_reg;
        if (state_reg != FREE && state_reg != ACTIVE && state_reg != DRAIN) begin
            state_next = FREE;
            head_next  = 1'b0;
            err        = 1'b1;
        end else begin
            if (send) begin
                if (state_reg != ACTIVE) begin
                    err = 1'b1;
                end else begin
                    if (is_head_label(label) == head_reg) err = 1'b1;
                    if (is_tail_label(label)) s1 = DRAIN;
                end
                if (!on_int) err = 1'b1;
            end
            s2 = s1;
            if (rel) begin
                if (s1 == DRAIN) s2 = FREE;
                else             err = 1'b1;
            end
            state_next = s2;
            if (grant) begin
                if (s2 == FREE) state_next = ACTIVE;
                else            err = 1'b1;
            end
            if (state_next != ACTIVE || (grant && s2 == FREE))
                head_next = 1'b0;
            else
                head_next = head_reg | (send & is_head_label(label));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= FREE;
            head_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            head_reg  <= head_next;
        end
    end

    assign free = (state_reg == FREE);
    assign on   = on_int;

endmodule

// File: rtl/output_link_tx.sv
// Upstream end of an inter-router link: registers crossbar flits onto the link and
// tracks downstream VCs. Optional counters enabled by OUTPUT_LINK_TX_STATS_EN.
module output_link_tx
    import noc_params::*;
#(
    parameter int VC_NUM      = noc_params::VC_NUM,
    parameter int ON_OFF_SYNC = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  flit_t              data_i,
    input  logic               valid_i,
    input  logic               alloc_valid_i,
    input  logic [VC_SIZE-1:0] alloc_vc_i,
    input  logic [VC_NUM-1:0]  on_off_i,
    input  logic [VC_NUM-1:0]  release_i,
    output flit_t              data_o,
    output logic               valid_o,
    output logic [VC_NUM-1:0]  vc_free_o,
    output logic [VC_NUM-1:0]  vc_on_o,
    output logic               error_o
`ifdef OUTPUT_LINK_TX_STATS_EN
    ,
    output logic [VC_NUM-1:0][15:0] flit_count_o,
    output logic [15:0]             packet_count_o
`endif
);

    flit_t             data_reg;
    logic              valid_reg;
    logic              error_reg;
    logic [VC_NUM-1:0] err_vec;
    logic [VC_NUM-1:0] send_vec;

    genvar gi;
    generate
        for (gi = 0; gi < VC_NUM; gi++) begin : g_vc
            logic grant;
            assign grant        = alloc_valid_i && (alloc_vc_i == VC_SIZE'(gi));
            assign send_vec[gi] = valid_i && (data_i.vc_id == VC_SIZE'(gi));

            downstream_vc_tracker #(
                .ON_OFF_SYNC (ON_OFF_SYNC)
            ) u_tracker (
                .clk    (clk),
                .rst    (rst),
                .grant  (grant),
                .send   (send_vec[gi]),
                .label  (data_i.label),
                .rel    (release_i[gi]),
                .on_off (on_off_i[gi]),
                .free   (vc_free_o[gi]),
                .on     (vc_on_o[gi]),
                .err    (err_vec[gi])
            );

`ifdef OUTPUT_LINK_TX_STATS_EN
            logic [15:0] flit_count_reg;
            always_ff @(posedge clk or posedge rst) begin
                if (rst)               flit_count_reg <= '0;
                else if (send_vec[gi]) flit_count_reg <= flit_count_reg + 16'd1;
            end
            assign flit_count_o[gi] = flit_count_reg;
`endif
        end
    endgenerate

    // Violating flits are still forwarded; only error_o reports them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_reg  <= '0;
            valid_reg <= 1'b0;
            error_reg <= 1'b0;
        end else begin
            valid_reg <= valid_i;
            if (valid_i) data_reg <= data_i;
            error_reg <= |err_vec;
        end
    end

`ifdef OUTPUT_LINK_TX_STATS_EN
    logic [15:0] packet_count_reg;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            packet_count_reg <= '0;
        else if (valid_i && is_tail_label(data_i.label))
            packet_count_reg <= packet_count_reg + 16'd1;
    end
    assign packet_count_o = packet_count_reg;
`endif

    assign data_o  = data_reg;
    assign valid_o = valid_reg;
    assign error_o = error_reg;

endmodule

// File: tb/tb_output_link_tx.sv
// Directed self-checking bench for output_link_tx; stats checks under OUTPUT_LINK_TX_STATS_EN.
module tb_output_link_tx;
    import noc_params::*;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    flit_t              data_i;
    logic               valid_i;
    logic               alloc_valid_i;
    logic [VC_SIZE-1:0] alloc_vc_i;
    logic [VC_NUM-1:0]  on_off_i;
    logic [VC_NUM-1:0]  release_i;
    flit_t              data_o;
    logic               valid_o;
    logic [VC_NUM-1:0]  vc_free_o;
    logic [VC_NUM-1:0]  vc_on_o;
    logic               error_o;
`ifdef OUTPUT_LINK_TX_STATS_EN
    logic [VC_NUM-1:0][15:0] flit_count_o;
    logic [15:0]             packet_count_o;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    output_link_tx dut (
        .clk           (clk),
        .rst           (rst),
        .data_i        (data_i),
        .valid_i       (valid_i),
        .alloc_valid_i (alloc_valid_i),
        .alloc_vc_i    (alloc_vc_i),
        .on_off_i      (on_off_i),
        .release_i     (release_i),
        .data_o        (data_o),
        .valid_o       (valid_o),
        .vc_free_o     (vc_free_o),
        .vc_on_o       (vc_on_o),
        .error_o       (error_o)
`ifdef OUTPUT_LINK_TX_STATS_EN
        ,
        .flit_count_o  (flit_count_o),
        .packet_count_o(packet_count_o)
`endif
    );

    function automatic flit_t mk(input flit_label_t l, input int vc, input logic [15:0] p);
        flit_t f;
        f.label   = l;
        f.vc_id   = VC_SIZE'(vc);
        f.payload = p;
        return f;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        valid_i       = 1'b0;
        alloc_valid_i = 1'b0;
        release_i     = '0;
    endtask

    task automatic drive_flit(input flit_label_t l, input int vc, input logic [15:0] p);
        data_i  = mk(l, vc, p);
        valid_i = 1'b1;
        $display("TX   vc=%0d label=%s payload=%h", vc, l.name(), p);
    endtask

    task automatic grant(input int vc);
        alloc_valid_i = 1'b1;
        alloc_vc_i    = VC_SIZE'(vc);
        $display("GRANT vc=%0d", vc);
    endtask

    task automatic test_reset();
        idle();
        on_off_i = '1;
        data_i   = '0;
        tick();
        drive_flit(BODY, 0, 16'hA5A5);
        tick();
        idle();
        #3 rst = 1'b1;
        #1;
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid_o); end
        checks++; if (data_o !== flit_t'(0)) begin errors++; $display("FAIL reset_data got %h want 0", data_o); end
        checks++; if (vc_free_o !== 4'b1111) begin errors++; $display("FAIL reset_free got %b want 1111", vc_free_o); end
        checks++; if (error_o !== 1'b0) begin errors++; $display("FAIL reset_error got %b want 0", error_o); end
        tick();
        tick();
        rst = 1'b0;
        tick();
        checks++; if (vc_on_o !== 4'b1111) begin errors++; $display("FAIL reset_on got %b want 1111", vc_on_o); end
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL post_reset_valid got %b want 0", valid_o); end
        checks++; if (vc_free_o !== 4'b1111) begin errors++; $display("FAIL post_reset_free got %b want 1111", vc_free_o); end
        checks++; if (error_o !== 1'b0) begin errors++; $display("FAIL post_reset_error got %b want 0", error_o); end
    endtask

    task automatic test_single_packet();
        flit_label_t labs[4];
        flit_t       exp;
        labs = '{HEAD, BODY, BODY, TAIL};
        grant(1);
        tick();
        idle();
        checks++; if (vc_free_o !== 4'b1101) begin errors++; $display("FAIL sp_grant_free got %b want 1101", vc_free_o); end
        checks++; if (error_o !== 1'b0) begin errors++; $display("FAIL sp_grant_error got %b want 0", error_o); end
        for (int i = 0; i < 4; i++) begin
            drive_flit(labs[i], 1, 16'h1100 + 16'(i));
            tick();
            idle();
            exp = mk(labs[i], 1, 16'h1100 + 16'(i));
            checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL sp_valid[%0d] got %b want 1", i, valid_o); end
            checks++; if (data_o !== exp) begin errors++; $display("FAIL sp_data[%0d] got %h want %h", i, data_o, exp); end
            checks++; if (error_o !== 1'b0) begin errors++; $display("FAIL sp_error[%0d] got %b want 0", i, error_o); end
        end
        checks++; if (vc_free_o !== 4'b1101) begin errors++; $display("FAIL sp_drain_free got %b want 1101", vc_free_o); end
        release_i = 4'b0010;
        $display("REL  vc=1");
        tick();
        idle();
        exp = mk(TAIL, 1, 16'h1103);
        checks++; if (vc_free_o !== 4'b1111) begin errors++; $display("FAIL sp_release_free got %b want 1111", vc_free_o); end
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL sp_idle_valid got %b want 0", valid_o); end
        checks++; if (data_o !== exp) begin errors++; $display("FAIL sp_data_hold got %h want %h", data_o, exp); end
        checks++; if (error_o !== 1'b0) begin errors++; $display("FAIL sp_release_error got %b want 0", error_o); end
    endtask

    task automatic test_headtail_regrant();
        grant(0);
        tick();
        idle();
        checks++; if (vc_free_o !== 4'b1110) begin errors++; $display("FAIL ht_grant_free got %b want 1110", vc_free_o); end
        drive_flit(HEADTAIL, 0, 16'h0A0A);
        release_i = 4'b0001;
        grant(0);
        tick();
        idle();
        checks++; if (vc_free_o !== 4'b1110) begin errors++; $display("FAIL ht_regrant_free got %b want 1110", vc_free_o); end
        checks++; if (error_o !== 1'b0) begin errors++; $display("FAIL ht_regrant_error got %b want 0", error_o); end
        checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL ht_valid got %b want 1", valid_o); end
        drive_flit(HEADTAIL, 0, 16'h0B0B);
        tick();
        idle();
        checks++; if (error_o !== 1'b0) begin errors++; $display("FAIL ht_second_error got %b want 0", error_o); end
        checks++; if (vc_free_o !== 4'b1110) begin errors++; $display("FAIL ht_drain_free got %b want 1110", vc_free_o); end
        release_i = 4'b0001;
        tick();
        idle();
        checks++; if (vc_free_o !== 4'b1111) begin errors++; $display("FAIL ht_release_free got %b want 1111", vc_free_o); end
        checks++; if (error_o !== 1'b0) begin errors++; $display("FAIL ht_release_error got %b want 0", error_o); end
    endtask

    task automatic test_flow_control();
        flit_t exp;
        grant(2);
        tick();
        idle();
        drive_flit(HEAD, 2, 16'h2200);
        tick();
        idle();
        checks++; if (error_o !== 1'b0) begin errors++; $display("FAIL fc_head_error got %b want 0", error_o); end
        on_off_i = 4'b1011;
        tick();
        checks++; if (vc_on_o !== 4'b1011) begin errors++; $display("FAIL fc_off got %b want 1011", vc_on_o); end
        drive_flit(BODY, 2, 16'h2201);
        tick();
        idle();
        exp = mk(BODY, 2, 16'h2201);
        checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL fc_off_valid got %b want 1", valid_o); end
        checks++; if (data_o !== exp) begin errors++; $display("FAIL fc_off_data got %h want %h", data_o, exp); end
        checks++; if (error_o !== 1'b1) begin errors++; $display("FAIL fc_off_error got %b want 1", error_o); end
        tick();
        checks++; if (error_o !== 1'b0) begin errors++; $display("FAIL fc_error_clear got %b want 0", error_o); end
        on_off_i = 4'b1111;
        tick();
        checks++; if (vc_on_o !== 4'b1111) begin errors++; $display("FAIL fc_on got %b want 1111", vc_on_o); end
        drive_flit(TAIL, 2, 16'h2202);
        tick();
        idle();
        checks++; if (error_o !== 1'b0) begin errors++; $display("FAIL fc_tail_error got %b want 0", error_o); end
        release_i = 4'b0100;
        tick();
        idle();
        checks++; if (vc_free_o !== 4'b1111) begin errors++; $display("FAIL fc_release_free got %b want 1111", vc_free_o); end
    endtask

    task automatic test_protocol_errors();
        grant(3);
        tick();
        idle();
        checks++; if (error_o !== 1'b0) begin errors++; $display("FAIL pe_first_grant got %b want 0", error_o); end
        grant(3);
        tick();
        idle();
        checks++; if (error_o !== 1'b1) begin errors++; $display("FAIL pe_regrant got %b want 1", error_o); end
        tick();
        checks++; if (error_o !== 1'b0) begin errors++; $display("FAIL pe_regrant_clear got %b want 0", error_o); end
        drive_flit(HEADTAIL, 3, 16'h3300);
        tick();
        idle();
        release_i = 4'b1000;
        tick();
        idle();
        checks++; if (vc_free_o !== 4'b1111) begin errors++; $display("FAIL pe_cleanup_free got %b want 1111", vc_free_o); end
        release_i = 4'b0010;
        $display("REL  vc=1 (free)");
        tick();
        idle();
        checks++; if (error_o !== 1'b1) begin errors++; $display("FAIL pe_release_free got %b want 1", error_o); end
        tick();
        checks++; if (error_o !== 1'b0) begin errors++; $display("FAIL pe_release_clear got %b want 0", error_o); end
        drive_flit(BODY, 1, 16'h1B1B);
        tick();
        idle();
        checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL pe_body_free_valid got %b want 1", valid_o); end
        checks++; if (error_o !== 1'b1) begin errors++; $display("FAIL pe_body_free_error got %b want 1", error_o); end
        tick();
        checks++; if (error_o !== 1'b0) begin errors++; $display("FAIL pe_body_clear got %b want 0", error_o); end
        checks++; if (vc_free_o !== 4'b1111) begin errors++; $display("FAIL pe_final_free got %b want 1111", vc_free_o); end
    endtask

`ifdef OUTPUT_LINK_TX_STATS_EN
    task automatic test_stats();
        flit_label_t labs[4];
        labs = '{HEAD, BODY, BODY, TAIL};
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        for (int p = 0; p < 3; p++) begin
            grant(0);
            tick();
            idle();
            for (int i = 0; i < 4; i++) begin
                drive_flit(labs[i], 0, 16'(p * 16 + i));
                tick();
                idle();
            end
            release_i = 4'b0001;
            tick();
            idle();
            checks++; if (error_o !== 1'b0) begin errors++; $display("FAIL st_error[%0d] got %b want 0", p, error_o); end
        end
        checks++; if (flit_count_o[0] !== 16'd12) begin errors++; $display("FAIL st_flit_count0 got %0d want 12", flit_count_o[0]); end
        checks++; if (flit_count_o[1] !== 16'd0) begin errors++; $display("FAIL st_flit_count1 got %0d want 0", flit_count_o[1]); end
        checks++; if (packet_count_o !== 16'd3) begin errors++; $display("FAIL st_packet_count got %0d want 3", packet_count_o); end
    endtask
`endif

    initial begin
        test_reset();
        test_single_packet();
        test_headtail_regrant();
        test_flow_control();
        test_protocol_errors();
`ifdef OUTPUT_LINK_TX_STATS_EN
        test_stats();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
